controlador_reservatorio_rolhas: RTL and testbench
==================================================

# controlador_reservatorio_rolhas

Cork-reservoir controller for the bottling line: owns the 7-bit cork count `reg_r` consumed by the cork-absence checker, and serves one-cork-per-bottle requests from the sealing station. Refills arrive from the dispenser in fixed-size batches and are transferred one cork per clock. The block is the sole writer of `reg_r`, and the sealing station and the absence checker read it.

## Interface
Parameters:
- `CAPACIDADE`, 100: maximum corks held. Legal range is 1..127.
- `LOTE`, 15: corks transferred per refill request. Legal range is 1..127.
- `CARGA_INICIAL`, 0: count loaded at reset. It must be ≤ `CAPACIDADE`.

Ports:
- `clk`, input, 1 bit: single clock, rising edge.
- `rst_n`, input, 1 bit: reset. Synchronous and active-low.
- `req_vedar`, input, 1 bit: the sealing station requests one cork. It is a level held until `ack_vedar`.
- `ack_vedar`, output, 1 bit: one-cycle pulse; one cork has been delivered.
- `req_repor`, input, 1 bit: refill request pulse from the dispenser/operator.
- `fim_repor`, output, 1 bit: one-cycle pulse when a refill completes.
- `reg_r`, output, 7 bits: current cork count, registered.
- `aus_rolhas`, output, 1 bit: high when `reg_r == 0`. Decoded from the register, no added latency.
- `cheio`, output, 1 bit: high when `reg_r == CAPACIDADE`.
- `ocupado`, output, 1 bit: high while in state REPOSICAO.

## Operation
- FSM states are OCIOSO, ENTREGA and REPOSICAO. Reset enters OCIOSO.
- Refill pending flag `pendente`:
  - It is set by `req_repor` in any state.
  - It is cleared when REPOSICAO is entered, or when a refill is discarded because the reservoir is full.
- OCIOSO, evaluated in priority order:
  - If `req_vedar` = 1 and `reg_r` > 0: decrement `reg_r`, pulse `ack_vedar`, go to ENTREGA.
  - Else if `pendente` = 1 and `reg_r` < `CAPACIDADE`:
    - Load `restante` = min(`LOTE`, `CAPACIDADE` − `reg_r`).
    - Clear `pendente` and go to REPOSICAO.
  - Else if `pendente` = 1 and `reg_r` == `CAPACIDADE`: clear `pendente`, pulse `fim_repor` (zero corks transferred), stay in OCIOSO.
  - If `req_vedar` = 1 and `reg_r` == 0: no ack; the request stalls until a refill adds corks.
- ENTREGA:
  - Wait for `req_vedar` = 0, then return to OCIOSO.
  - No second ack is issued while the request is still held.
- REPOSICAO:
  - Each cycle, `reg_r` += 1 and `restante` −= 1.
  - On the cycle `restante` reaches 0, pulse `fim_repor` and return to OCIOSO.
  - `req_vedar` is not served during REPOSICAO; it waits.
- Arithmetic:
  - `reg_r` never exceeds `CAPACIDADE` and never underflows below 0.
  - `restante` is 7 bits wide. The min() is computed at the 8-bit width.
- Reset mid-operation: `reg_r` = `CARGA_INICIAL`, `restante` = 0, `pendente` = 0, state OCIOSO. Any refill in progress is lost.

## Timing
- Reset values:
  - `reg_r` = `CARGA_INICIAL`.
  - `ack_vedar` = 0, `fim_repor` = 0, `ocupado` = 0.
  - `aus_rolhas` and `cheio` follow the decode of `reg_r`.
- Delivery: `req_vedar` is sampled high in OCIOSO at edge N. At edge N+1, `ack_vedar` = 1 and `reg_r` has already been decremented.
- Minimum spacing between two acks:
  - 3 cycles: ack, then at least one cycle of `req_vedar` low, then the next request.
- Refill of k corks:
  - `ocupado` is high for k cycles, starting the cycle after the decision in OCIOSO.
  - `reg_r` increments once per cycle.
  - `fim_repor` coincides with the final increment.
- Simultaneous `req_vedar` and `pendente` in OCIOSO: the delivery wins. The refill starts after return to OCIOSO with `req_vedar` low.
- `req_repor` arriving during REPOSICAO sets `pendente`, which yields a second batch afterward.

## Structure
- Shared package `pkg_engarrafadora`:
  - State enum `estado_reservatorio_t` (OCIOSO, ENTREGA, REPOSICAO).
  - Constant `LARG_ROLHAS` = 7.
- One sub-module, `contador_rolhas`: saturating up/down counter with parameterised load value and `CAPACIDADE`.
  - Inputs: `inc`, `dec`, `carregar`.
  - Output: `reg_r`.
  - The FSM, `pendente` and `restante` stay in the top module.

## Test plan
- Reset with `CARGA_INICIAL` = 0:
  - `reg_r` = 0, `aus_rolhas` = 1.
  - `req_vedar` held for 10 cycles gives no `ack_vedar`.
- From count 0, pulse `req_repor`:
  - `ocupado` is high for 15 cycles and `reg_r` steps 1..15.
  - `fim_repor` pulses with `reg_r` = 15, then `aus_rolhas` = 0.
- With count 3, run three full request/ack handshakes:
  - Three single-cycle acks, `reg_r` goes 2, 1, 0, then `aus_rolhas` = 1.
  - A fourth request stalls with no ack.
- With count 95, pulse `req_repor`: 5 corks transfer, `reg_r` = 100, `cheio` = 1.
  - A further `req_repor` produces `fim_repor` the next cycle with `reg_r` unchanged.
- With count 10 in OCIOSO, raise `req_vedar` and `req_repor` on the same edge:
  - Ack first, `reg_r` = 9.
  - After `req_vedar` is dropped, the refill brings `reg_r` to 24.
- Assert `rst_n` = 0 during REPOSICAO at `reg_r` = 7:
  - The next edge gives `reg_r` = `CARGA_INICIAL`, `ocupado` = 0, and no `fim_repor`.

Source files
------------

// File: rtl/controlador_reservatorio_rolhas_pkg.sv
// Shared bottling-line types: reservoir FSM states and cork-count width.
package pkg_engarrafadora;

  localparam int LARG_ROLHAS = 7;

  typedef enum logic [1:0] {
    OCIOSO,
    ENTREGA,
    REPOSICAO
  } estado_reservatorio_t;

  // Batch size clipped to the free space; both operands at 8 bits so the subtraction cannot wrap.
  function automatic logic [LARG_ROLHAS-1:0] min_lote(input logic [7:0] lote, input logic [7:0] espaco);
    logic [7:0] m;
    m = (lote < espaco) ? lote : espaco;
    return m[LARG_ROLHAS-1:0];
  endfunction

endpackage

// File: rtl/controlador_reservatorio_rolhas_if.sv
// Sealing-station / dispenser side of the cork reservoir controller.
interface controlador_reservatorio_rolhas_if;
  import pkg_engarrafadora::*;

  logic                   req_vedar;
  logic                   ack_vedar;
  logic                   req_repor;
  logic                   fim_repor;
  logic [LARG_ROLHAS-1:0] reg_r;
  logic                   aus_rolhas;
  logic                   cheio;
  logic                   ocupado;

  modport master (
    output req_vedar, req_repor,
    input  ack_vedar, fim_repor, reg_r, aus_rolhas, cheio, ocupado
  );

  modport slave (
    input  req_vedar, req_repor,
    output ack_vedar, fim_repor, reg_r, aus_rolhas, cheio, ocupado
  );
endinterface

// File: rtl/controlador_reservatorio_rolhas_contador.sv
// Saturating cork counter; carregar reloads the start value and overrides inc/dec.
module contador_rolhas
  import pkg_engarrafadora::*;
#(
  parameter int CAPACIDADE    = 100,
  parameter int CARGA_INICIAL = 0
) (
  input  logic                   clk,
  input  logic                   carregar,
  input  logic                   inc,
  input  logic                   dec,
  output logic [LARG_ROLHAS-1:0] reg_r
);

  localparam logic [LARG_ROLHAS-1:0] CAP   = LARG_ROLHAS'(CAPACIDADE);
  localparam logic [LARG_ROLHAS-1:0] CARGA = LARG_ROLHAS'(CARGA_INICIAL);

  always_ff @(posedge clk) begin
    if (carregar)
      reg_r <= CARGA;
    else if (inc && !dec && reg_r < CAP)
      reg_r <= reg_r + 1'b1;
    else if (dec && !inc && reg_r != '0)
      reg_r <= reg_r - 1'b1;
  end

endmodule

// File: rtl/controlador_reservatorio_rolhas.sv
// Cork reservoir controller: serves one cork per sealing request and
// transfers refill batches one cork per clock.
module controlador_reservatorio_rolhas
  import pkg_engarrafadora::*;
#(
  parameter int CAPACIDADE    = 100,
  parameter int LOTE          = 15,
  parameter int CARGA_INICIAL = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  controlador_reservatorio_rolhas_if.slave   bus
);

  localparam logic [LARG_ROLHAS-1:0] CAP  = LARG_ROLHAS'(CAPACIDADE);
  localparam logic [LARG_ROLHAS-1:0] LOTE7 = LARG_ROLHAS'(LOTE);

  estado_reservatorio_t   estado;
  logic                   pendente;
  logic [LARG_ROLHAS-1:0] restante;
  logic [LARG_ROLHAS-1:0] contagem;
  logic                   ack_q, fim_q, ocupado_q;
  logic                   inc, dec, carregar, limpar;
  logic [7:0]             espaco;
  logic [LARG_ROLHAS-1:0] lote_carga;

  assign carregar   = !rst_n;
  assign dec        = rst_n && (estado == OCIOSO) && bus.req_vedar && (contagem != '0);
  assign inc        = rst_n && (estado == REPOSICAO) && (restante != '0);
  // Delivery has priority; otherwise a pending refill is consumed (started or discarded).
  assign limpar     = (estado == OCIOSO) && !dec && pendente;
  assign espaco     = {1'b0, CAP} - {1'b0, contagem};
  assign lote_carga = min_lote({1'b0, LOTE7}, espaco);

  contador_rolhas #(
    .CAPACIDADE    (CAPACIDADE),
    .CARGA_INICIAL (CARGA_INICIAL)
  ) u_contador (
    .clk      (clk),
    .carregar (carregar),
    .inc      (inc),
    .dec      (dec),
    .reg_r    (contagem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      pendente  <= 1'b0;
      restante  <= '0;
      ack_q     <= 1'b0;
      fim_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      fim_q    <= 1'b0;
      pendente <= bus.req_repor | (pendente & ~limpar);
      case (estado)
        OCIOSO: begin
          if (dec) begin
            ack_q  <= 1'b1;
            estado <= ENTREGA;
          end else if (pendente && contagem < CAP) begin
            restante  <= lote_carga;
            ocupado_q <= 1'b1;
            estado    <= REPOSICAO;
          end else if (pendente) begin
            fim_q <= 1'b1;
          end
        end
        ENTREGA: begin
          if (!bus.req_vedar)
            estado <= OCIOSO;
        end
        REPOSICAO: begin
          restante <= restante - 1'b1;
          if (restante <= LARG_ROLHAS'(1)) begin
            fim_q     <= 1'b1;
            ocupado_q <= 1'b0;
            estado    <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.ack_vedar  = ack_q;
  assign bus.fim_repor  = fim_q;
  assign bus.ocupado    = ocupado_q;
  assign bus.reg_r      = contagem;
  assign bus.aus_rolhas = (contagem == '0);
  assign bus.cheio      = (contagem == CAP);

endmodule

// File: tb/tb_controlador_reservatorio_rolhas.sv
// Bench for the cork reservoir controller: cycle model plus directed scenarios.
module tb_controlador_reservatorio_rolhas;

  localparam int CAP  = 100;
  localparam int LOTE = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controlador_reservatorio_rolhas_if bus();

  controlador_reservatorio_rolhas #(
    .CAPACIDADE    (CAP),
    .LOTE          (LOTE),
    .CARGA_INICIAL (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  // Model: corks held, corks still to transfer in the active batch, pending refill,
  // and whether an acked request is still being held by the station.
  int m_count = 0;
  int m_left  = 0;
  bit m_pend  = 0;
  bit m_hold  = 0;
  bit m_ack   = 0;
  bit m_fim   = 0;
  bit chk_en  = 0;

  always @(posedge clk) begin : modelo
    bit consumed;
    consumed = 0;
    if (!rst_n) begin
      m_count = 0; m_left = 0; m_pend = 0; m_hold = 0; m_ack = 0; m_fim = 0;
    end else begin
      m_ack = 0;
      m_fim = 0;
      if (m_left > 0) begin
        m_count++;
        m_left--;
        if (m_left == 0) m_fim = 1;
      end else if (m_hold) begin
        if (!bus.req_vedar) m_hold = 0;
      end else if (bus.req_vedar && m_count > 0) begin
        m_count--;
        m_ack  = 1;
        m_hold = 1;
      end else if (m_pend) begin
        consumed = 1;
        if (m_count < CAP) m_left = (LOTE < CAP - m_count) ? LOTE : CAP - m_count;
        else m_fim = 1;
      end
      m_pend = bus.req_repor || (m_pend && !consumed);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model reg_r",      32'(bus.reg_r),      32'(m_count));
      chk("model ack_vedar",  32'(bus.ack_vedar),  32'(m_ack));
      chk("model fim_repor",  32'(bus.fim_repor),  32'(m_fim));
      chk("model ocupado",    32'(bus.ocupado),    32'(m_left > 0));
      chk("model aus_rolhas", 32'(bus.aus_rolhas), 32'(m_count == 0));
      chk("model cheio",      32'(bus.cheio),      32'(m_count == CAP));
    end
  end

  task automatic stall(input string nome);
    int acks;
    acks = 0;
    bus.req_vedar = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack_vedar) acks++;
    end
    bus.req_vedar = 1'b0;
    @(negedge clk);
    chk(nome, acks, 0);
  endtask

  task automatic handshake(output logic [31:0] r);
    bit got;
    got = 0;
    r = '1;
    bus.req_vedar = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack_vedar) begin
        got = 1;
        r = 32'(bus.reg_r);
        break;
      end
    end
    bus.req_vedar = 1'b0;
    @(negedge clk);
    chk("ack within budget", 32'(got), 1);
  endtask

  task automatic entregar(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) handshake(r);
  endtask

  task automatic refill(output int busy, output int iters, output logic [31:0] last);
    bit done;
    done = 0; busy = 0; iters = 0; last = '1;
    bus.req_repor = 1'b1;
    @(negedge clk);
    bus.req_repor = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      iters++;
      if (bus.ocupado) busy++;
      if (bus.fim_repor) begin
        done = 1;
        last = 32'(bus.reg_r);
        break;
      end
    end
    chk("fim_repor within budget", 32'(done), 1);
  endtask

  initial begin
    int busy, iters;
    logic [31:0] last, r;
    bit found;

    bus.req_vedar = 1'b0;
    bus.req_repor = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("reset reg_r", 32'(bus.reg_r), 0);
    chk("reset aus_rolhas", 32'(bus.aus_rolhas), 1);
    chk("reset ack_vedar", 32'(bus.ack_vedar), 0);
    chk("reset ocupado", 32'(bus.ocupado), 0);
    rst_n = 1'b1;
    @(negedge clk);

    stall("no ack when empty");

    refill(busy, iters, last);
    chk("first refill busy cycles", busy, 15);
    chk("first refill final count", last, 15);
    chk("not empty after refill", 32'(bus.aus_rolhas), 0);

    entregar(12);
    handshake(r); chk("ack count 2", r, 2);
    handshake(r); chk("ack count 1", r, 1);
    handshake(r); chk("ack count 0", r, 0);
    chk("empty after three acks", 32'(bus.aus_rolhas), 1);
    stall("fourth request stalls");

    for (int i = 0; i < 7; i++) refill(busy, iters, last);
    chk("seventh refill clipped batch", busy, 10);
    chk("seventh refill reaches capacity", last, 100);

    entregar(5);
    chk("count 95", 32'(bus.reg_r), 95);
    refill(busy, iters, last);
    chk("top-up busy cycles", busy, 5);
    chk("top-up final count", last, 100);
    chk("cheio at capacity", 32'(bus.cheio), 1);
    refill(busy, iters, last);
    chk("discard latency", iters, 1);
    chk("discard busy cycles", busy, 0);
    chk("discard keeps count", last, 100);

    entregar(90);
    chk("count 10", 32'(bus.reg_r), 10);
    bus.req_vedar = 1'b1;
    bus.req_repor = 1'b1;
    @(negedge clk);
    bus.req_repor = 1'b0;
    chk("simultaneous: ack first", 32'(bus.ack_vedar), 1);
    chk("simultaneous: count 9", 32'(bus.reg_r), 9);
    bus.req_vedar = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.fim_repor) begin
        found = 1;
        last = 32'(bus.reg_r);
        break;
      end
    end
    chk("deferred refill completes", 32'(found), 1);
    chk("deferred refill count 24", last, 24);

    entregar(24);
    bus.req_repor = 1'b1;
    @(negedge clk);
    bus.req_repor = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ocupado && bus.reg_r == 7'd7) begin
        found = 1;
        break;
      end
    end
    chk("reached 7 during refill", 32'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset reg_r", 32'(bus.reg_r), 0);
    chk("mid reset ocupado", 32'(bus.ocupado), 0);
    chk("mid reset fim_repor", 32'(bus.fim_repor), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("refill lost after reset", 32'(bus.reg_r), 0);
    chk("idle after reset", 32'(bus.ocupado), 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
